// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, cache address split and frame layout.
// Default icache geometry is ICACHE_NFRAMES frames of one word each.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_IW      = 4;
    localparam int ICACHE_TW      = 26;

    typedef struct packed {
        logic [ICACHE_TW-1:0] tag;
        logic [ICACHE_IW-1:0] idx;
        logic [1:0]           bytoff;
    } icachef_t;

    typedef struct packed {
        logic                 valid;
        logic [ICACHE_TW-1:0] tag;
        word_t                data;
    } icache_frame_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side handshake bundle of the icache.
// slave: cache view; master: core + memory controller view.
interface icache_direct_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  iwait;

    modport slave (
        input  imemREN, imemaddr, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frame_array.sv
// Frame storage: one combinational read port, one synchronous write
// port, synchronous clear of every frame while nRST is low.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES,
    parameter int IW      = $clog2(NFRAMES),
    parameter int TW      = 30 - IW
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output word_t         rd_data,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  word_t         wr_data
);

    logic [NFRAMES-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q  [NFRAMES];
    logic [TW-1:0]      tag_d  [NFRAMES];
    word_t              data_q [NFRAMES];
    word_t              data_d [NFRAMES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < NFRAMES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-block icache with IDLE/FILL controller.
// Ports: CLK, nRST, bus (icache_direct_if.slave); hit_count/miss_count
// exist only when ICACHE_STATS_EN is defined.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES
) (
    input  logic CLK,
    input  logic nRST,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int IW = $clog2(NFRAMES);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state_q, state_d;
    word_t  miss_addr_q, miss_addr_d;

    logic [IW-1:0] rd_idx;
    logic [TW-1:0] req_tag;
    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    word_t         rd_data;
    logic          we;
    logic          hit;
    logic          iren;
    word_t         iaddr;
    logic          unused_bits;

    assign rd_idx  = bus.imemaddr[IW+1:2];
    assign req_tag = bus.imemaddr[31:IW+2];
    assign unused_bits = ^{bus.imemaddr[1:0], miss_addr_q[1:0]};

    icache_frame_array #(
        .NFRAMES (NFRAMES),
        .IW      (IW),
        .TW      (TW)
    ) u_frames (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (we),
        .wr_idx   (miss_addr_q[IW+1:2]),
        .wr_tag   (miss_addr_q[31:IW+2]),
        .wr_data  (bus.iload)
    );

    assign hit = (state_q == IDLE) && bus.imemREN &&
                 rd_valid && (rd_tag == req_tag);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        iren        = 1'b0;
        iaddr       = '0;
        we          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.imemREN && !hit) begin
                    miss_addr_d = {bus.imemaddr[31:2], 2'b00};
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Redirects are ignored: the fill finishes on the latched word.
                iren  = 1'b1;
                iaddr = miss_addr_q;
                if (!bus.iwait) begin
                    we      = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    assign bus.ihit     = hit;
    assign bus.imemload = rd_data;
    assign bus.iREN     = iren;
    assign bus.iaddr    = iaddr;

`ifdef ICACHE_STATS_EN
    word_t hit_count_q, hit_count_d;
    word_t miss_count_q, miss_count_d;
    logic  miss_start;

    assign miss_start = (state_q == IDLE) && (state_d == FILL);

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && hit_count_q != '1)
            hit_count_d = hit_count_q + 32'd1;
        if (miss_start && miss_count_q != '1)
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
